gpio_cmd_bridge: RTL and testbench
==================================

// Module: gpio_cmd_bridge
// PURPOSE
//   Upstream feeder for the PS<->PL GPIO pair: decodes PS commands written over the
//   two AXI-GPIO output words, buffers pushed data words in a FIFO and streams them to
//   a PL consumer over a valid/ready port. Returns status and ack over the GPIO inputs.
//   Toggle handshake on bit 31 lets PS software poll without any interrupt.
// PARAMETERS
//   DEPTH   16  FIFO depth in words; power of two, >= 2
//   DATA_W  32  stream width; data taken from PS_2_PL_1_tri_o[DATA_W-1:0]; <= 32
// PORTS
//   clk              in   1       single clock domain; AXI GPIO runs on the same clock
//   reset            in   1       synchronous, active-high
//   PS_2_PL_0_tri_o  in   32      [31] req toggle, [30:28] opcode, [27] data parity, rest ignored
//   PS_2_PL_1_tri_o  in   32      command data word
//   PL_2_PS_0_tri_i  out  32      status word, see BEHAVIOUR
//   PL_2_PS_1_tri_i  out  32      response data word
//   m_data           out  DATA_W  FIFO head word
//   m_valid          out  1       FIFO non-empty
//   m_ready          in   1       consumer accepts m_data when m_valid & m_ready
//   led              out  2       [0] = m_valid, [1] = err
// BEHAVIOUR
// - Clock/reset: one clock, clk; reset is synchronous, active-high.
// - Reset values: ack_tog=0, err=0, FIFO empty (count=0, m_valid=0), m_data=0,
//   push_total=0, PL_2_PS_1_tri_i=0, state IDLE.
// - Status word (combinational from registers):
//   [31]=ack_tog, [30]=err, [29]=full, [28]=empty, [27:16]=0, [15:0]=count.
// - Handshake: a command is pending when PS_2_PL_0_tri_o[31] != ack_tog.
//   - PS changes opcode/data and flips req in one GPIO write.
//   - PS waits for ack_tog == req before issuing the next command.
//   - A req still at 1 after reset is a new command and executes.
// - FSM: IDLE -> EXEC -> ACK -> IDLE.
//   - IDLE: on pending req, register opcode and data (cycle N).
//   - EXEC (N+1): execute opcode; err is written with the result of this command.
//   - ACK (N+2): ack_tog <= req. Req edges seen while in EXEC/ACK are ignored until IDLE.
// - Opcodes:
//   - 0 NOP: err=0.
//   - 1 PUSH: if !full, write data[DATA_W-1:0] at wr_ptr and increment push_total, err=0;
//     if full, err=1 and no write. A pop in the same cycle does not rescue a full PUSH.
//   - 2 STATUS: PL_2_PS_1_tri_i <= push_total (32-bit, wraps at 2^32), err=0.
//   - 3 CLEAR: pointers and count -> 0, err=0; clear wins over a same-cycle pop.
//     A word handed out in that cycle is still considered consumed.
//   - 4..7: err=1, no other state change.
// - PL_2_PS_1_tri_i is changed only by STATUS; it holds its value otherwise.
// - FIFO: first-word-fall-through; m_data = mem[rd_ptr].
//   - Pop when m_valid & m_ready; no pop when empty.
//   - Push and pop in the same cycle: count unchanged.
//   - Pointers wrap modulo DEPTH; count width $clog2(DEPTH)+1; full when count==DEPTH.
// - Stream: m_valid=!empty; m_data stable while m_valid & !m_ready.
// - Reset mid-command: FSM aborts to IDLE with ack_tog=0 and the FIFO flushed;
//   an in-flight PUSH is not written.
// CONFIGURATION
//   GPIO_PARITY_CHK_EN
//   - Defined: PUSH checks PS_2_PL_0_tri_o[27] == ^PS_2_PL_1_tri_o (even parity over 32 bits).
//     On mismatch: err=1, no write, push_total unchanged.
//   - Undefined: bit 27 is ignored and there is no parity logic.
// TESTING
//   T1 push 0xA1,0xB2,0xC3 with m_ready=0 -> ack toggles 2 cycles after each req edge;
//      status count=3, empty=0, led[0]=1.
//   T2 then m_ready=1 -> m_data 0xA1,0xB2,0xC3 on 3 consecutive cycles;
//      then m_valid=0, status empty=1, count=0.
//   T3 17 PUSHes, DEPTH=16, m_ready=0 -> first 16 err=0; 17th err=1, full=1, count=16;
//      STATUS then returns 16.
//   T4 opcode 5 with FIFO at 4 words -> err=1, led[1]=1, count stays 4;
//      next NOP clears err.
//   T5 CLEAR while full with m_ready=1 -> after ack count=0, empty=1, m_valid=0.
//      Assert reset in the EXEC cycle of a PUSH -> count=0, ack_tog=0.
//   T6 (GPIO_PARITY_CHK_EN) PUSH 0x00000001 with bit27=0 -> err=1, count unchanged;
//      with bit27=1 -> err=0, count+1.

Source files
------------

// File: rtl/gpio_cmd_bridge_if.sv
// rtl/gpio_cmd_bridge_if.sv - GPIO word pair and PL stream bundle for gpio_cmd_bridge
interface gpio_cmd_bridge_if #(
    parameter int DATA_W = 32
);
    logic [31:0]       PS_2_PL_0_tri_o;
    logic [31:0]       PS_2_PL_1_tri_o;
    logic [31:0]       PL_2_PS_0_tri_i;
    logic [31:0]       PL_2_PS_1_tri_i;
    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_ready;

    modport master (
        output PS_2_PL_0_tri_o, PS_2_PL_1_tri_o, m_ready,
        input  PL_2_PS_0_tri_i, PL_2_PS_1_tri_i, m_data, m_valid
    );

    modport slave (
        input  PS_2_PL_0_tri_o, PS_2_PL_1_tri_o, m_ready,
        output PL_2_PS_0_tri_i, PL_2_PS_1_tri_i, m_data, m_valid
    );
endinterface

// File: rtl/gpio_cmd_bridge.sv
// rtl/gpio_cmd_bridge.sv - PS GPIO command decoder feeding a FWFT FIFO stream; GPIO_PARITY_CHK_EN adds PUSH parity check
module gpio_cmd_bridge #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    gpio_cmd_bridge_if.slave    bus,
    output logic [1:0]          led
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [2:0] OP_NOP    = 3'd0;
    localparam logic [2:0] OP_PUSH   = 3'd1;
    localparam logic [2:0] OP_STATUS = 3'd2;
    localparam logic [2:0] OP_CLEAR  = 3'd3;

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, ACK = 2'd2} state_t;

    state_t            state;
    logic              ack_tog;
    logic              err;
    logic              req_q;
    logic [2:0]        op_q;
    logic [31:0]       data_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [31:0]       push_total;
    logic [31:0]       resp;
    logic              full;
    logic              empty;
    logic              pop;
    logic              push_ok;
    logic              do_push;
    logic              do_clear;
    logic              unused_bits;

`ifdef GPIO_PARITY_CHK_EN
    logic par_q;
    assign push_ok     = !full && (par_q == ^data_q);
    assign unused_bits = ^bus.PS_2_PL_0_tri_o[26:0];
`else
    assign push_ok     = !full;
    assign unused_bits = ^bus.PS_2_PL_0_tri_o[27:0];
`endif

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign pop      = !empty && bus.m_ready;
    assign do_push  = (state == EXEC) && (op_q == OP_PUSH) && push_ok;
    assign do_clear = (state == EXEC) && (op_q == OP_CLEAR);

    // Gate the head word so m_data reads 0 whenever the FIFO is empty.
    assign bus.m_data          = empty ? '0 : mem[rd_ptr];
    assign bus.m_valid         = !empty;
    assign bus.PL_2_PS_0_tri_i = {ack_tog, err, full, empty, 12'd0, 16'(count)};
    assign bus.PL_2_PS_1_tri_i = resp;
    assign led                 = {err, !empty};

    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem[wr_ptr] <= data_q[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ack_tog    <= 1'b0;
            err        <= 1'b0;
            req_q      <= 1'b0;
            op_q       <= OP_NOP;
            data_q     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            push_total <= '0;
            resp       <= '0;
`ifdef GPIO_PARITY_CHK_EN
            par_q      <= 1'b0;
`endif
        end else begin
            // Clear overrides both the pointer moves and the count arithmetic.
            if (do_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CW'(do_push) - CW'(pop);
            end

            case (state)
                IDLE: begin
                    if (bus.PS_2_PL_0_tri_o[31] != ack_tog) begin
                        req_q  <= bus.PS_2_PL_0_tri_o[31];
                        op_q   <= bus.PS_2_PL_0_tri_o[30:28];
                        data_q <= bus.PS_2_PL_1_tri_o;
`ifdef GPIO_PARITY_CHK_EN
                        par_q  <= bus.PS_2_PL_0_tri_o[27];
`endif
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    case (op_q)
                        OP_NOP:    err <= 1'b0;
                        OP_PUSH: begin
                            err <= !push_ok;
                            if (push_ok) begin
                                push_total <= push_total + 32'd1;
                            end
                        end
                        OP_STATUS: begin
                            resp <= push_total;
                            err  <= 1'b0;
                        end
                        OP_CLEAR:  err <= 1'b0;
                        default:   err <= 1'b1;
                    endcase
                    state <= ACK;
                end
                ACK: begin
                    ack_tog <= req_q;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_cmd_bridge.sv
// tb/tb_gpio_cmd_bridge.sv - scoreboard bench for gpio_cmd_bridge; GPIO_PARITY_CHK_EN enables the parity vectors
module tb_gpio_cmd_bridge;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] led;
    logic       req = 1'b0;
    int         n_checks = 0;
    int         n_fail = 0;

    typedef struct packed {
        logic        ack;
        logic        err;
        logic [15:0] cnt;
        logic        chk_resp;
        logic [31:0] resp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] stream_q[$];

    gpio_cmd_bridge_if #(.DATA_W(32)) bus ();

    gpio_cmd_bridge #(.DEPTH(16), .DATA_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .led   (led)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Ack monitor: every ack_tog transition must match the oldest queued expectation.
    logic prev_ack = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        logic [31:0] exp_st;
        if (reset) begin
            prev_ack = 1'b0;
        end else if (bus.PL_2_PS_0_tri_i[31] !== prev_ack) begin
            prev_ack = bus.PL_2_PS_0_tri_i[31];
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                exp_st = {e.ack, e.err, (e.cnt == 16'd16), (e.cnt == 16'd0), 12'd0, e.cnt};
                chk("status_word", bus.PL_2_PS_0_tri_i, exp_st);
                chk("led", {30'd0, led}, {30'd0, e.err, (e.cnt != 16'd0)});
                if (e.chk_resp) begin
                    chk("status_resp", bus.PL_2_PS_1_tri_i, e.resp);
                end
            end
        end
    end

    // Stream monitor: each accepted word must be the oldest expected word.
    always @(negedge clk) begin
        if (!reset && bus.m_valid && bus.m_ready) begin
            if (stream_q.size() == 0) begin
                chk("unexpected_word", bus.m_data, 32'hFFFF_FFFF);
            end else begin
                chk("stream_data", bus.m_data, stream_q.pop_front());
            end
        end
    end

    task automatic wait_ack(input string name);
        int lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (bus.PL_2_PS_0_tri_i[31] == req) begin
                lat = c;
                break;
            end
        end
        chk(name, lat, 3);
    endtask

    task automatic cmd(input logic [2:0] op, input logic [31:0] d, input logic par,
                       input logic exp_err, input int exp_cnt, input logic rdy,
                       input logic chk_resp, input logic [31:0] exp_resp);
        exp_t e;
        @(posedge clk);
        #1;
        req = ~req;
        e.ack = req;
        e.err = exp_err;
        e.cnt = 16'(exp_cnt);
        e.chk_resp = chk_resp;
        e.resp = exp_resp;
        exp_q.push_back(e);
        if (op == 3'd1 && !exp_err) begin
            stream_q.push_back(d);
        end
        bus.PS_2_PL_0_tri_o = {req, op, par, 27'd0};
        bus.PS_2_PL_1_tri_o = d;
        bus.m_ready = rdy;
        wait_ack("ack_latency");
        if (op == 3'd3) begin
            stream_q.delete();
        end
    endtask

    task automatic push(input logic [31:0] d, input logic exp_err, input int exp_cnt);
        cmd(3'd1, d, ^d, exp_err, exp_cnt, 1'b0, 1'b0, 32'd0);
    endtask

    task automatic reset_dut();
        @(posedge clk);
        #1;
        reset = 1'b1;
        req = 1'b0;
        bus.PS_2_PL_0_tri_o = 32'd0;
        bus.PS_2_PL_1_tri_o = 32'd0;
        bus.m_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        stream_q.delete();
    endtask

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation exceeded time bound");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bus.PS_2_PL_0_tri_o = 32'd0;
        bus.PS_2_PL_1_tri_o = 32'd0;
        bus.m_ready = 1'b0;
        reset_dut();

        chk("reset_status", bus.PL_2_PS_0_tri_i, 32'h1000_0000);
        chk("reset_resp", bus.PL_2_PS_1_tri_i, 32'd0);
        chk("reset_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("reset_m_data", bus.m_data, 32'd0);
        chk("reset_led", {30'd0, led}, 32'd0);

        // T1: three pushes held back by m_ready=0
        push(32'h0000_00A1, 1'b0, 1);
        push(32'h0000_00B2, 1'b0, 2);
        push(32'h0000_00C3, 1'b0, 3);
        chk("t1_head", bus.m_data, 32'h0000_00A1);
        chk("t1_led0", {31'd0, led[0]}, 32'd1);

        // T2: drain on three consecutive cycles
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t2_drained", stream_q.size(), 0);
        chk("t2_m_valid", {31'd0, bus.m_valid}, 32'd0);
        chk("t2_status", bus.PL_2_PS_0_tri_i & 32'h1000_FFFF, 32'h1000_0000);
        bus.m_ready = 1'b0;

        // T3: fill to DEPTH, 17th push overflows, STATUS reports 16
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            push(32'h0000_0100 + 32'(i), 1'b0, i + 1);
        end
        push(32'h0000_0777, 1'b1, 16);
        cmd(3'd2, 32'd0, 1'b0, 1'b0, 16, 1'b0, 1'b1, 32'd16);

        // T5a: CLEAR while full, consumer starts accepting at the same time
        cmd(3'd3, 32'd0, 1'b0, 1'b0, 0, 1'b1, 1'b0, 32'd0);
        chk("t5_m_valid", {31'd0, bus.m_valid}, 32'd0);
        bus.m_ready = 1'b0;

        // T4: illegal opcodes with four words queued, NOP clears err
        push(32'h1111_1111, 1'b0, 1);
        push(32'h2222_2222, 1'b0, 2);
        push(32'h3333_3333, 1'b0, 3);
        push(32'h4444_4444, 1'b0, 4);
        cmd(3'd5, 32'd0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 32'd0);
        chk("t4_led1", {31'd0, led[1]}, 32'd1);
        cmd(3'd0, 32'd0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 32'd0);
        cmd(3'd7, 32'd0, 1'b0, 1'b1, 4, 1'b0, 1'b0, 32'd0);
        cmd(3'd0, 32'd0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 32'd0);

        // T5b: reset in the EXEC cycle of a PUSH; req left at 1 re-executes afterwards
        if (req) begin
            cmd(3'd0, 32'd0, 1'b0, 1'b0, 4, 1'b0, 1'b0, 32'd0);
        end
        @(posedge clk);
        #1;
        req = 1'b1;
        bus.PS_2_PL_0_tri_o = {1'b1, 3'd1, 1'b0, 27'd0};
        bus.PS_2_PL_1_tri_o = 32'hDEAD_0001;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_count", {16'd0, bus.PL_2_PS_0_tri_i[15:0]}, 32'd0);
        chk("abort_ack", {31'd0, bus.PL_2_PS_0_tri_i[31]}, 32'd0);
        chk("abort_m_valid", {31'd0, bus.m_valid}, 32'd0);
        stream_q.delete();
        exp_q.push_back('{ack: 1'b1, err: 1'b0, cnt: 16'd1, chk_resp: 1'b0, resp: 32'd0});
        stream_q.push_back(32'hDEAD_0001);
        wait_ack("reexec_latency");
        @(posedge clk);
        #1;
        bus.m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.m_ready = 1'b0;
        chk("reexec_drained", stream_q.size(), 0);

`ifdef GPIO_PARITY_CHK_EN
        // T6: parity over the full 32-bit data word
        cmd(3'd1, 32'h0000_0001, 1'b0, 1'b1, 0, 1'b0, 1'b0, 32'd0);
        cmd(3'd1, 32'h0000_0001, 1'b1, 1'b0, 1, 1'b0, 1'b0, 32'd0);
        cmd(3'd2, 32'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1, 32'd2);
`endif

        repeat (4) @(posedge clk);
        #1;
        chk("acks_outstanding", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
